// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT frame controller slice.
// Holds the controller state encoding, default parameter values and the frame-length helper.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int DEF_DATA_W       = 32;
    localparam int DEF_LOG2_N       = 10;
    localparam int DEF_FLUSH_LEN    = 128;
    localparam int DEF_MAX_FRAMES_W = 8;
    localparam int DEF_TIMEOUT_CYC  = 65536;

    function automatic int frame_len(input int log2_n);
        return 1 << log2_n;
    endfunction

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// Sample stream between upstream source, frame controller and FFT core.
// The controller takes the slave view; the environment (source plus core) takes the master view.
interface fft_frame_ctrl_if
    import fft_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_real;
    logic [DATA_W-1:0] s_imag;
    logic              o_valid_in;
    logic [DATA_W-1:0] o_data_real;
    logic [DATA_W-1:0] o_data_imag;
    logic              i_valid_out;

    modport slave (
        input  s_valid, s_real, s_imag, i_valid_out,
        output s_ready, o_valid_in, o_data_real, o_data_imag
    );

    modport master (
        output s_valid, s_real, s_imag, i_valid_out,
        input  s_ready, o_valid_in, o_data_real, o_data_imag
    );

endinterface

// File: rtl/fft_watchdog.sv
// Idle-cycle watchdog: counts enabled cycles without a kick and flags the TIMEOUT_CYC-th one.
module fft_watchdog
    import fft_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic kick,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] idle_cnt;

    // Saturates at the limit so a late FSM exit cannot wrap the count.
    always_ff @(posedge i_clk) begin
        if (i_reset || !enable || kick)
            idle_cnt <= '0;
        else if (!expired)
            idle_cnt <= idle_cnt + CNT_W'(1);
    end

    assign expired = enable && !kick && (idle_cnt == LIMIT);

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame controller for a streaming FFT core: feeds frames, flushes with zeros, counts output pairs.
// Define FFT_FRAME_CTRL_LATENCY_EN to compile in the first-sample-to-first-pair latency counter.
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int LOG2_N       = DEF_LOG2_N,
    parameter int FLUSH_LEN    = DEF_FLUSH_LEN,
    parameter int MAX_FRAMES_W = DEF_MAX_FRAMES_W,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [MAX_FRAMES_W-1:0] i_num_frames,
    fft_frame_ctrl_if.slave         bus,
    output logic                    o_frame_done,
    output logic [MAX_FRAMES_W-1:0] o_frame_cnt,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_timeout,
    output logic                    o_err,
    output logic [31:0]             o_latency
);

    localparam int N      = frame_len(LOG2_N);
    localparam int HALF   = N / 2;
    localparam int IN_W   = MAX_FRAMES_W + LOG2_N;
    localparam int FL_W   = $clog2(FLUSH_LEN + 1);
    localparam int PAIR_W = (LOG2_N > 1) ? LOG2_N - 1 : 1;

    state_t                  state, state_nxt;
    logic [MAX_FRAMES_W-1:0] frames_q;
    logic [IN_W-1:0]         in_cnt, in_last;
    logic [FL_W-1:0]         flush_cnt;
    logic [PAIR_W-1:0]       pair_cnt;
    logic                    accept, pair_in, pair_wrap, run_done, flush_last;
    logic                    wd_enable, wd_expired, start_run;

    assign bus.s_ready = (state == FEED) && !i_reset;
    assign accept      = bus.s_valid && bus.s_ready;
    assign start_run   = (state == IDLE) && i_start;
    assign pair_in     = bus.i_valid_out && (state != IDLE);
    assign pair_wrap   = pair_in && (pair_cnt == PAIR_W'(HALF - 1));
    assign run_done    = pair_wrap && ((o_frame_cnt + MAX_FRAMES_W'(1)) == frames_q);
    assign in_last     = (IN_W'(frames_q) << LOG2_N) - IN_W'(1);
    assign flush_last  = (flush_cnt == FL_W'(FLUSH_LEN - 1));
    assign wd_enable   = (state == FLUSH) || (state == DRAIN);
    assign o_busy      = (state != IDLE);

    fft_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .kick    (bus.i_valid_out),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Run completion and watchdog expiry override the per-state transition, so a
    // final pair landing on the last flush cycle ends the run instead of draining.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = FEED;
            FEED:    if (accept && (in_cnt == in_last)) state_nxt = FLUSH;
            FLUSH:   if (flush_last) state_nxt = DRAIN;
            DRAIN:   state_nxt = DRAIN;
            default: state_nxt = IDLE;
        endcase
        if ((state != IDLE) && (run_done || wd_expired))
            state_nxt = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bus.o_valid_in  <= 1'b0;
            bus.o_data_real <= '0;
            bus.o_data_imag <= '0;
            frames_q        <= '0;
            in_cnt          <= '0;
            flush_cnt       <= '0;
            pair_cnt        <= '0;
            o_frame_cnt     <= '0;
            o_frame_done    <= 1'b0;
            o_done          <= 1'b0;
            o_timeout       <= 1'b0;
            o_err           <= 1'b0;
        end else begin
            bus.o_valid_in  <= accept || (state == FLUSH);
            bus.o_data_real <= accept ? bus.s_real : {DATA_W{1'b0}};
            bus.o_data_imag <= accept ? bus.s_imag : {DATA_W{1'b0}};
            o_frame_done    <= pair_wrap;
            if (start_run) begin
                frames_q    <= (i_num_frames == '0) ? MAX_FRAMES_W'(1) : i_num_frames;
                in_cnt      <= '0;
                flush_cnt   <= '0;
                pair_cnt    <= '0;
                o_frame_cnt <= '0;
                o_done      <= 1'b0;
                o_timeout   <= 1'b0;
                o_err       <= 1'b0;
            end else begin
                if (accept)
                    in_cnt <= in_cnt + IN_W'(1);
                flush_cnt <= (state == FLUSH) ? flush_cnt + FL_W'(1) : '0;
                if (pair_in)
                    pair_cnt <= pair_wrap ? '0 : pair_cnt + PAIR_W'(1);
                if (pair_wrap)
                    o_frame_cnt <= o_frame_cnt + MAX_FRAMES_W'(1);
                if (run_done)
                    o_done <= 1'b1;
                else if (wd_expired && (state != IDLE))
                    o_timeout <= 1'b1;
            end
            // A stray core strobe while idle is flagged even if a start arrives alongside it.
            if ((state == IDLE) && bus.i_valid_out)
                o_err <= 1'b1;
        end
    end

`ifdef FFT_FRAME_CTRL_LATENCY_EN
    logic [31:0] lat_cnt;
    logic        lat_armed;

    // Arms on the first accepted sample of a run and captures on the first core strobe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lat_cnt   <= '0;
            lat_armed <= 1'b0;
            o_latency <= '0;
        end else if (start_run) begin
            lat_cnt   <= '0;
            lat_armed <= 1'b0;
            o_latency <= '0;
        end else if (accept && (in_cnt == '0)) begin
            lat_cnt   <= 32'd1;
            lat_armed <= !pair_in;
            o_latency <= '0;
        end else if (lat_armed) begin
            if (pair_in) begin
                o_latency <= lat_cnt;
                lat_armed <= 1'b0;
            end else begin
                lat_cnt <= lat_cnt + 32'd1;
            end
        end
    end
`else
    assign o_latency = '0;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl with N=16, FLUSH_LEN=4, TIMEOUT_CYC=50.
// Expected o_valid_in beats and frame-done counts are queued as stimulus is driven.
module tb_fft_frame_ctrl;
    import fft_pkg::*;

    localparam int DW        = 16;
    localparam int LOG2_N    = 4;
    localparam int N         = 16;
    localparam int FLUSH_LEN = 4;
    localparam int MFW       = 8;
    localparam int TO_CYC    = 50;

    logic           i_clk = 1'b0;
    logic           i_reset;
    logic           i_start;
    logic [MFW-1:0] i_num_frames;
    logic           o_frame_done;
    logic [MFW-1:0] o_frame_cnt;
    logic           o_busy, o_done, o_timeout, o_err;
    logic [31:0]    o_latency;

    fft_frame_ctrl_if #(.DATA_W(DW)) bus ();

    fft_frame_ctrl #(
        .DATA_W(DW), .LOG2_N(LOG2_N), .FLUSH_LEN(FLUSH_LEN),
        .MAX_FRAMES_W(MFW), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_num_frames (i_num_frames),
        .bus          (bus),
        .o_frame_done (o_frame_done),
        .o_frame_cnt  (o_frame_cnt),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_timeout    (o_timeout),
        .o_err        (o_err),
        .o_latency    (o_latency)
    );

    always #5 i_clk = ~i_clk;

    int          total = 0;
    int          bad = 0;
    int          beats = 0;
    int          cyc = 0;
    int          first_cyc = 0;
    bit          first_acc = 1'b0;
    logic [31:0] data_q[$];
    int          frame_q[$];
    logic [63:0] mon_exp;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic int exp_latency(input int delay);
`ifdef FFT_FRAME_CTRL_LATENCY_EN
        return delay;
`else
        return (delay < 0) ? delay : 0;
`endif
    endfunction

    // Monitor: every beat to the core and every frame-done pulse is matched against the queues.
    always @(negedge i_clk) begin
        if (bus.o_valid_in === 1'b1) begin
            beats++;
            if (data_q.size() > 0) mon_exp = {32'h0, data_q.pop_front()};
            else mon_exp = '1;
            checkOutput("beat_data", {32'h0, bus.o_data_real, bus.o_data_imag}, mon_exp);
        end
        if (o_frame_done === 1'b1) begin
            if (frame_q.size() > 0) mon_exp = 64'(frame_q.pop_front());
            else mon_exp = '1;
            checkOutput("frame_done_cnt", 64'(o_frame_cnt), mon_exp);
        end
    end

    task automatic feed(input int count, input bit toggle, input bit poke, input bit push_flush);
        int acc = 0;
        for (int j = 0; (acc < count) && (j < 4 * count + 20); j++) begin
            bus.s_valid = toggle ? (j % 2 == 0) : 1'b1;
            bus.s_real  = DW'($urandom);
            bus.s_imag  = DW'($urandom);
            i_start     = poke && (j == 5);
            if (bus.s_valid && bus.s_ready) begin
                data_q.push_back({bus.s_real, bus.s_imag});
                if (acc == 0) begin
                    first_cyc = cyc;
                    first_acc = 1'b1;
                end
                acc++;
            end
            tick();
        end
        bus.s_valid = 1'b0;
        i_start     = 1'b0;
        checkOutput("feed_count", acc, count);
        if (push_flush) repeat (FLUSH_LEN) data_q.push_back('0);
    endtask

    // Core model: first pair arrives 'delay' cycles after the first accepted sample.
    task automatic core(input int delay, input int npairs);
        int w = 0;
        if (npairs == 0) return;
        while (!first_acc && w < 2000) begin
            tick();
            w++;
        end
        if (!first_acc) return;
        while (cyc < first_cyc + delay) tick();
        for (int p = 1; p <= npairs; p++) begin
            bus.i_valid_out = 1'b1;
            if (p % (N / 2) == 0) frame_q.push_back(p / (N / 2));
            tick();
        end
        bus.i_valid_out = 1'b0;
    endtask

    task automatic applyStimulus(input logic [MFW-1:0] nf, input bit toggle, input int delay,
                                 input int npairs, input int count, input bit poke, input bit push_flush);
        data_q.delete();
        frame_q.delete();
        beats        = 0;
        first_acc    = 1'b0;
        i_num_frames = nf;
        i_start      = 1'b1;
        tick();
        i_start = 1'b0;
        if (poke) i_num_frames = 8'd7;
        fork
            feed(count, toggle, poke, push_flush);
            core(delay, npairs);
        join
    endtask

    task automatic finish_run(input string tag, input int frames, input int exp_beats, input int delay);
        int k = 0;
        while (o_busy && k < 300) begin
            tick();
            k++;
        end
        tick();
        tick();
        $display("[TB] checking %s", tag);
        checkOutput({tag, "_busy"}, o_busy, 0);
        checkOutput({tag, "_done"}, o_done, 1);
        checkOutput({tag, "_frame_cnt"}, o_frame_cnt, frames);
        checkOutput({tag, "_timeout"}, o_timeout, 0);
        checkOutput({tag, "_err"}, o_err, 0);
        checkOutput({tag, "_beats"}, beats, exp_beats);
        checkOutput({tag, "_sb_data_left"}, data_q.size(), 0);
        checkOutput({tag, "_sb_frame_left"}, frame_q.size(), 0);
        checkOutput({tag, "_latency"}, o_latency, exp_latency(delay));
    endtask

    task automatic check_quiet(input string tag);
        checkOutput({tag, "_s_ready"}, bus.s_ready, 0);
        checkOutput({tag, "_valid_in"}, bus.o_valid_in, 0);
        checkOutput({tag, "_data"}, {bus.o_data_real, bus.o_data_imag}, 0);
        checkOutput({tag, "_status"}, {o_frame_done, o_busy, o_done, o_timeout, o_err}, 0);
        checkOutput({tag, "_frame_cnt"}, o_frame_cnt, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_time_limit: got running expected finished");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        i_reset         = 1'b1;
        i_start         = 1'b0;
        i_num_frames    = '0;
        bus.s_valid     = 1'b0;
        bus.s_real      = '0;
        bus.s_imag      = '0;
        bus.i_valid_out = 1'b0;
        repeat (3) tick();
        check_quiet("reset");
        checkOutput("reset_latency", o_latency, 0);
        i_reset = 1'b0;
        tick();

        bus.i_valid_out = 1'b1;
        tick();
        bus.i_valid_out = 1'b0;
        checkOutput("idle_pair_err", o_err, 1);
        checkOutput("idle_pair_cnt", o_frame_cnt, 0);
        checkOutput("idle_pair_busy", o_busy, 0);

        applyStimulus(8'd2, 1'b0, 20, 16, 32, 1'b0, 1'b1);
        finish_run("contig", 2, 36, 20);

        applyStimulus(8'd2, 1'b1, 70, 16, 32, 1'b1, 1'b1);
        finish_run("toggle", 2, 36, 70);

        applyStimulus(8'd1, 1'b0, 0, 0, 10, 1'b0, 1'b0);
        i_reset = 1'b1;
        tick();
        check_quiet("midrun_reset");
        i_reset = 1'b0;
        tick();
        checkOutput("midrun_reset_beats", beats, 10);
        checkOutput("midrun_reset_sb_left", data_q.size(), 0);

        applyStimulus(8'd0, 1'b0, 25, 8, 16, 1'b0, 1'b1);
        finish_run("zero_frames", 1, 20, 25);

        applyStimulus(8'd1, 1'b0, 25, 7, 16, 1'b0, 1'b1);
        repeat (TO_CYC - 1) tick();
        checkOutput("wd_before_timeout", o_timeout, 0);
        checkOutput("wd_before_busy", o_busy, 1);
        tick();
        checkOutput("wd_timeout", o_timeout, 1);
        checkOutput("wd_busy", o_busy, 0);
        checkOutput("wd_done", o_done, 0);
        checkOutput("wd_frame_cnt", o_frame_cnt, 0);
        checkOutput("wd_sb_left", data_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, sample component width.
REQ-002 SHALL have parameter LOG2_N, default 10, log2 of the FFT frame length N (N=1024).
REQ-003 SHALL have parameter FLUSH_LEN, default 128, number of zero samples injected after the last frame.
REQ-004 SHALL have parameter MAX_FRAMES_W, default 8, width of the frame-count request.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 65536, idle-output cycles before abort.
REQ-006 i_clk  in  1  single clock; all logic rises on posedge.
REQ-007 i_reset  in  1  synchronous, active-high reset.
REQ-008 i_start  in  1  one-cycle pulse; launches a run.
REQ-009 i_num_frames  in  MAX_FRAMES_W  frames per run; 0 is treated as 1.
REQ-010 s_valid, s_real, s_imag  in  1, DATA_W, DATA_W  upstream sample stream.
REQ-011 s_ready  out  1  upstream accept; high only in FEED.
REQ-012 o_valid_in, o_data_real, o_data_imag  out  1, DATA_W, DATA_W  drive to the FFT core.
REQ-013 i_valid_out  in  1  FFT core output-pair strobe (one pair = bins A and B).
REQ-014 o_frame_done  out  1  one-cycle pulse per N/2 received pairs.
REQ-015 o_frame_cnt  out  MAX_FRAMES_W  completed output frames in the current run.
REQ-016 o_busy, o_done, o_timeout, o_err  out  1 each  status (see Function).
REQ-017 o_latency  out  32  first-sample-to-first-pair cycle count.

Function
REQ-018 The FSM SHALL have states IDLE, FEED, FLUSH, DRAIN.
REQ-019 IDLE->FEED on i_start; the FSM SHALL latch i_num_frames and clear the counters, o_done, o_timeout, and o_err.
REQ-020 i_start SHALL be ignored outside IDLE.
REQ-021 In FEED, o_valid_in SHALL equal s_valid&&s_ready, registered with data; latency is 1 cycle.
REQ-022 The input counter SHALL count accepted samples; FEED->FLUSH on the cycle the (frames*N)-th sample is accepted.
REQ-023 Upstream gaps (s_valid=0) SHALL leave o_valid_in low and SHALL NOT advance counters.
REQ-024 In FLUSH, the block SHALL drive o_valid_in=1 with zero data for exactly FLUSH_LEN cycles, then go to DRAIN.
REQ-025 The pair counter SHALL count i_valid_out in FEED, FLUSH, and DRAIN, and SHALL wrap at N/2-1.
REQ-026 At each wrap, o_frame_done SHALL pulse and o_frame_cnt SHALL increment.
REQ-027 When o_frame_cnt reaches the latched frame count, the FSM SHALL go to IDLE from any non-IDLE state, pulse o_done, and drop o_busy.
REQ-028 If pair completion coincides with the last flush cycle, completion SHALL win and the next state is IDLE.
REQ-029 Watchdog: in FLUSH or DRAIN, count cycles without i_valid_out.
REQ-030 When the watchdog reaches TIMEOUT_CYC, o_timeout SHALL be set (sticky) and the FSM SHALL go to IDLE.
REQ-031 i_valid_out in IDLE SHALL set o_err (sticky) and SHALL NOT be counted.
REQ-032 o_busy SHALL be high in all states except IDLE.

Reset
REQ-033 While i_reset=1, the FSM SHALL be in IDLE and all counters zero.
REQ-034 While i_reset=1, s_ready, o_valid_in, o_frame_done, o_busy, o_done, o_timeout, and o_err SHALL be 0, and o_data_* and o_frame_cnt SHALL be 0.
REQ-035 Reset mid-run SHALL abort immediately; no flush is issued.

Configuration
REQ-036 Macro FFT_FRAME_CTRL_LATENCY_EN SHALL compile in the latency measurement.
REQ-037 With the macro defined, o_latency SHALL be captured as cycles from the first accepted sample to the first i_valid_out of the run, held until the next i_start.
REQ-038 Without the macro, o_latency SHALL be constant 0 and the counter SHALL be absent.

Structure
REQ-039 The FSM state enum, default parameter constants, and frame length helper SHALL live in the shared package fft_pkg.
REQ-040 The watchdog SHALL be a sub-module fft_watchdog, with ports kick, enable, and expired.

Verification (LOG2_N=4, N=16, FLUSH_LEN=4, TIMEOUT_CYC=50)
REQ-041 Start with frames=2; send 32 contiguous samples; model the core returning 16 pairs. Required: 4 flush cycles with zero data; o_frame_done after pair 8 and pair 16; o_done; o_frame_cnt=2.
REQ-042 Same run with s_valid toggling every other cycle. Required: exactly 32 o_valid_in beats before flush, and identical results.
REQ-043 Frames=1 with only 7 pairs returned. Required: o_timeout=1 at 50 idle cycles after the last pair; IDLE; o_busy=0.
REQ-044 Assert i_reset mid-FEED at sample 10. Required: next cycle all outputs 0; a following i_start runs normally.
REQ-045 i_valid_out pulsed in IDLE. Required: o_err=1, o_frame_cnt=0. i_start during FEED is ignored.
REQ-046 With FFT_FRAME_CTRL_LATENCY_EN and a core latency of 20 cycles after the first sample: o_latency=20. Without the macro: o_latency=0.
